// File: rtl/packet_transfer_arbiter_pkg.sv
// Shared types for the packet transfer arbiter: the flit word and the arbiter's
// state and source encodings.
package types;
  typedef logic [15:0] flit_t;
endpackage

package packet_types;
  typedef enum logic [1:0] {
    IDLE,
    LOCK_NOC,
    LOCK_CPU
  } arb_state_e;

  typedef enum logic {
    SRC_NOC = 1'b0,
    SRC_CPU = 1'b1
  } arb_src_e;
endpackage

// File: rtl/packet_transfer_arbiter.sv
// Wormhole arbiter sharing the router input between the NOC and CPU flit streams.
// Optional statistics counters are enabled by defining PACKET_TRANSFER_ARBITER_STATS_EN.
module packet_transfer_arbiter
  import packet_types::*;
#(
  parameter int unsigned NOC_WEIGHT       = 4,
  parameter int unsigned MAX_PACKET_FLITS = 16,
  parameter int unsigned CNT_W            = 16
) (
  input  logic         nocclk,
  input  logic         rst_n,
  input  types::flit_t noc_flit,
  input  logic         noc_flit_valid,
  input  logic         noc_flit_last,
  output logic         noc_flit_ready,
  input  types::flit_t cpu_flit,
  input  logic         cpu_flit_valid,
  input  logic         cpu_flit_last,
  output logic         cpu_flit_ready,
  output types::flit_t out_flit,
  output logic         out_flit_valid,
  input  logic         out_flit_ready,
  output types::flit_t out_head_flit,
  output logic         out_src,
  output logic         busy,
  output logic         pkt_len_err
`ifdef PACKET_TRANSFER_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] noc_pkt_cnt,
  output logic [CNT_W-1:0] cpu_pkt_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned WCNT_W = $clog2(NOC_WEIGHT + 1);
  localparam int unsigned FCNT_W = $clog2(MAX_PACKET_FLITS + 1);
  localparam logic [WCNT_W-1:0] WEIGHT_MAX = WCNT_W'(NOC_WEIGHT);
  localparam logic [FCNT_W-1:0] FLIT_FINAL = FCNT_W'(MAX_PACKET_FLITS - 1);

  if (NOC_WEIGHT < 1 || MAX_PACKET_FLITS < 2 || CNT_W < 1) begin : g_bad_param
    $error("packet_transfer_arbiter: illegal parameter value");
  end

  arb_state_e        state_q, state_d;
  arb_src_e          last_src_q, last_src_d;
  logic [WCNT_W-1:0] weight_q, weight_d;
  logic [FCNT_W-1:0] flit_cnt_q, flit_cnt_d;
  types::flit_t      head_q, head_d;
  logic              src_q, src_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic sel_last;
  logic handshake;
  logic pick_cpu;

  // Unregistered pass-through of the locked source.
  always_comb begin
    out_flit       = '0;
    out_flit_valid = 1'b0;
    noc_flit_ready = 1'b0;
    cpu_flit_ready = 1'b0;
    sel_last       = 1'b0;
    case (state_q)
      LOCK_NOC: begin
        out_flit       = noc_flit;
        out_flit_valid = noc_flit_valid;
        noc_flit_ready = out_flit_ready;
        sel_last       = noc_flit_last;
      end
      LOCK_CPU: begin
        out_flit       = cpu_flit;
        out_flit_valid = cpu_flit_valid;
        cpu_flit_ready = out_flit_ready;
        sel_last       = cpu_flit_last;
      end
      default: ;
    endcase
  end

  assign handshake = out_flit_valid & out_flit_ready;

  always_comb begin
    state_d    = state_q;
    last_src_d = last_src_q;
    weight_d   = weight_q;
    flit_cnt_d = flit_cnt_q;
    head_d     = head_q;
    err_d      = err_q;
    pick_cpu   = 1'b0;
    case (state_q)
      IDLE: begin
        flit_cnt_d = '0;
        pick_cpu   = (noc_flit_valid && cpu_flit_valid)
                     ? (weight_q == WEIGHT_MAX || last_src_q == SRC_NOC)
                     : cpu_flit_valid;
        if (pick_cpu) begin
          state_d    = LOCK_CPU;
          last_src_d = SRC_CPU;
          weight_d   = '0;
        end else if (noc_flit_valid) begin
          state_d    = LOCK_NOC;
          last_src_d = SRC_NOC;
          if (cpu_flit_valid && weight_q != WEIGHT_MAX) weight_d = weight_q + WCNT_W'(1);
        end
      end
      default: begin
        if (handshake) begin
          if (flit_cnt_q == '0) head_d = out_flit;
          if (sel_last) begin
            state_d    = IDLE;
            flit_cnt_d = '0;
          end else if (flit_cnt_q == FLIT_FINAL) begin
            // Oversized packet: drop the lock so the remainder re-arbitrates.
            state_d    = IDLE;
            flit_cnt_d = '0;
            err_d      = 1'b1;
          end else begin
            flit_cnt_d = flit_cnt_q + FCNT_W'(1);
          end
        end
      end
    endcase
    busy_d = (state_d != IDLE);
    src_d  = (state_d == LOCK_CPU);
  end

  // last_src resets to CPU so the first contested arbitration goes to NOC.
  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_src_q <= SRC_CPU;
      weight_q   <= '0;
      flit_cnt_q <= '0;
      head_q     <= '0;
      src_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_src_q <= last_src_d;
      weight_q   <= weight_d;
      flit_cnt_q <= flit_cnt_d;
      head_q     <= head_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign out_head_flit = head_q;
  assign out_src       = src_q;
  assign busy          = busy_q;
  assign pkt_len_err   = err_q;

`ifdef PACKET_TRANSFER_ARBITER_STATS_EN
  logic [CNT_W-1:0] noc_pkt_cnt_q, noc_pkt_cnt_d;
  logic [CNT_W-1:0] cpu_pkt_cnt_q, cpu_pkt_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    noc_pkt_cnt_d = noc_pkt_cnt_q;
    cpu_pkt_cnt_d = cpu_pkt_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (handshake && sel_last && state_q == LOCK_NOC) noc_pkt_cnt_d = noc_pkt_cnt_q + CNT_W'(1);
    if (handshake && sel_last && state_q == LOCK_CPU) cpu_pkt_cnt_d = cpu_pkt_cnt_q + CNT_W'(1);
    if (out_flit_valid && !out_flit_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge nocclk or negedge rst_n) begin
    if (!rst_n) begin
      noc_pkt_cnt_q <= '0;
      cpu_pkt_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      noc_pkt_cnt_q <= noc_pkt_cnt_d;
      cpu_pkt_cnt_q <= cpu_pkt_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign noc_pkt_cnt = noc_pkt_cnt_q;
  assign cpu_pkt_cnt = cpu_pkt_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_packet_transfer_arbiter.sv
// Directed bench for packet_transfer_arbiter: a packet-level reference model is
// compared against the DUT on every falling edge, plus literal expectations per scenario.
module tb_packet_transfer_arbiter;
  localparam int NOC_WEIGHT = 4;
  localparam int MAXF       = 16;
  localparam int CNT_W      = 16;

  typedef types::flit_t flit_t;
  typedef struct packed { flit_t d; logic last; } beat_t;
  typedef struct packed { logic src; flit_t d; logic last; } obs_t;

  logic  nocclk = 1'b0;
  logic  rst_n;
  flit_t noc_flit = '0;
  logic  noc_flit_valid = 1'b0;
  logic  noc_flit_last = 1'b0;
  logic  noc_flit_ready;
  flit_t cpu_flit = '0;
  logic  cpu_flit_valid = 1'b0;
  logic  cpu_flit_last = 1'b0;
  logic  cpu_flit_ready;
  flit_t out_flit;
  logic  out_flit_valid;
  logic  out_flit_ready = 1'b1;
  flit_t out_head_flit;
  logic  out_src;
  logic  busy;
  logic  pkt_len_err;
`ifdef PACKET_TRANSFER_ARBITER_STATS_EN
  logic [CNT_W-1:0] noc_pkt_cnt, cpu_pkt_cnt, stall_cnt;
`endif

  packet_transfer_arbiter #(
    .NOC_WEIGHT(NOC_WEIGHT),
    .MAX_PACKET_FLITS(MAXF),
    .CNT_W(CNT_W)
  ) dut (
    .nocclk(nocclk),
    .rst_n(rst_n),
    .noc_flit(noc_flit),
    .noc_flit_valid(noc_flit_valid),
    .noc_flit_last(noc_flit_last),
    .noc_flit_ready(noc_flit_ready),
    .cpu_flit(cpu_flit),
    .cpu_flit_valid(cpu_flit_valid),
    .cpu_flit_last(cpu_flit_last),
    .cpu_flit_ready(cpu_flit_ready),
    .out_flit(out_flit),
    .out_flit_valid(out_flit_valid),
    .out_flit_ready(out_flit_ready),
    .out_head_flit(out_head_flit),
    .out_src(out_src),
    .busy(busy),
    .pkt_len_err(pkt_len_err)
`ifdef PACKET_TRANSFER_ARBITER_STATS_EN
    ,
    .noc_pkt_cnt(noc_pkt_cnt),
    .cpu_pkt_cnt(cpu_pkt_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 nocclk = ~nocclk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkf(string name, flit_t act, flit_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkc(string name, logic [CNT_W-1:0] act, logic [CNT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Source drivers: each queue holds the beats a buffer still has to offer.
  beat_t noc_q[$];
  beat_t cpu_q[$];
  logic  pop_noc = 1'b0;
  logic  pop_cpu = 1'b0;

  always @(posedge nocclk) begin
    #1;
    if (pop_noc && noc_q.size() > 0) noc_q.delete(0);
    if (pop_cpu && cpu_q.size() > 0) cpu_q.delete(0);
    noc_flit_valid = (noc_q.size() > 0);
    noc_flit       = (noc_q.size() > 0) ? noc_q[0].d : '0;
    noc_flit_last  = (noc_q.size() > 0) ? noc_q[0].last : 1'b0;
    cpu_flit_valid = (cpu_q.size() > 0);
    cpu_flit       = (cpu_q.size() > 0) ? cpu_q[0].d : '0;
    cpu_flit_last  = (cpu_q.size() > 0) ? cpu_q[0].last : 1'b0;
  end

  // Reference model: owner 0 = none, 1 = NOC, 2 = CPU.
  int               m_owner;
  int               m_flits;
  flit_t            m_head;
  logic             m_err;
  int               m_run;
  logic             m_last_cpu;
  logic [CNT_W-1:0] m_noc_pk, m_cpu_pk, m_stall;
  obs_t             log_q[$];

  always @(negedge nocclk) begin
    flit_t e_flit;
    logic  e_valid, e_last, to_cpu;
    obs_t  o;
    if (!rst_n) begin
      m_owner = 0; m_flits = 0; m_head = '0; m_err = 1'b0; m_run = 0; m_last_cpu = 1'b1;
      m_noc_pk = '0; m_cpu_pk = '0; m_stall = '0;
    end
    e_valid = 1'b0; e_flit = '0; e_last = 1'b0;
    if (m_owner == 1) begin
      e_valid = noc_flit_valid; e_flit = noc_flit; e_last = noc_flit_last;
    end else if (m_owner == 2) begin
      e_valid = cpu_flit_valid; e_flit = cpu_flit; e_last = cpu_flit_last;
    end
    chk1("out_flit_valid", out_flit_valid, e_valid);
    chkf("out_flit", out_flit, e_flit);
    chk1("noc_flit_ready", noc_flit_ready, (m_owner == 1) && out_flit_ready);
    chk1("cpu_flit_ready", cpu_flit_ready, (m_owner == 2) && out_flit_ready);
    chk1("out_src", out_src, m_owner == 2);
    chk1("busy", busy, m_owner != 0);
    chkf("out_head_flit", out_head_flit, m_head);
    chk1("pkt_len_err", pkt_len_err, m_err);
`ifdef PACKET_TRANSFER_ARBITER_STATS_EN
    chkc("noc_pkt_cnt", noc_pkt_cnt, m_noc_pk);
    chkc("cpu_pkt_cnt", cpu_pkt_cnt, m_cpu_pk);
    chkc("stall_cnt", stall_cnt, m_stall);
`endif
    pop_noc = rst_n && noc_flit_valid && noc_flit_ready;
    pop_cpu = rst_n && cpu_flit_valid && cpu_flit_ready;
    if (rst_n) begin
      if (out_flit_valid && out_flit_ready) begin
        o.src  = out_src;
        o.d    = out_flit;
        o.last = out_src ? cpu_flit_last : noc_flit_last;
        log_q.push_back(o);
      end
      if (e_valid && !out_flit_ready && m_stall != '1) m_stall = m_stall + 1'b1;
      if (m_owner == 0) begin
        if (noc_flit_valid || cpu_flit_valid) begin
          if (noc_flit_valid && cpu_flit_valid) to_cpu = (m_run == NOC_WEIGHT) || !m_last_cpu;
          else to_cpu = cpu_flit_valid;
          if (to_cpu) begin
            m_owner = 2; m_last_cpu = 1'b1; m_run = 0;
          end else begin
            m_owner = 1; m_last_cpu = 1'b0;
            if (cpu_flit_valid && m_run < NOC_WEIGHT) m_run++;
          end
        end
      end else if (e_valid && out_flit_ready) begin
        if (m_flits == 0) m_head = e_flit;
        m_flits++;
        if (e_last) begin
          if (m_owner == 1) m_noc_pk = m_noc_pk + 1'b1;
          else m_cpu_pk = m_cpu_pk + 1'b1;
          m_owner = 0; m_flits = 0;
        end else if (m_flits == MAXF) begin
          m_err = 1'b1; m_owner = 0; m_flits = 0;
        end
      end
    end
  end

  task automatic after_neg();
    @(negedge nocclk);
    #2;
  endtask

  task automatic push_pkt(bit cpu, flit_t base, int n, bit with_last);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d    = base + flit_t'(i);
      b.last = with_last && (i == n - 1);
      if (cpu) cpu_q.push_back(b);
      else noc_q.push_back(b);
    end
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    forever begin
      @(negedge nocclk);
      #1;
      if (noc_q.size() == 0 && cpu_q.size() == 0 && !busy) break;
      n++;
      if (n > 400) begin
        checks++;
        errors++;
        $display("FAIL %s timeout waiting for idle actual=busy required=idle", name);
        break;
      end
    end
  endtask

  task automatic wait_log(string name, int target);
    int n;
    n = 0;
    forever begin
      @(negedge nocclk);
      #1;
      if (log_q.size() >= target) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL %s timeout actual=%0d required=%0d handshakes", name, log_q.size(), target);
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    after_neg();
    rst_n = 1'b0;
    after_neg();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, run;
    rst_n = 1'b0;
    #3;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_out_valid", out_flit_valid, 1'b0);
    chk1("rst_noc_ready", noc_flit_ready, 1'b0);
    chk1("rst_cpu_ready", cpu_flit_ready, 1'b0);
    chk1("rst_out_src", out_src, 1'b0);
    chk1("rst_err", pkt_len_err, 1'b0);
    chkf("rst_head", out_head_flit, 16'h0000);
    repeat (2) after_neg();
    rst_n = 1'b1;

    // 1: single NOC packet, one-cycle arbitration bubble
    after_neg();
    l0 = log_q.size();
    push_pkt(1'b0, 16'h00A1, 3, 1'b1);
    @(negedge nocclk); #1;
    chk1("t1_valid_presented", noc_flit_valid, 1'b1);
    chk1("t1_busy_bubble", busy, 1'b0);
    @(negedge nocclk); #1;
    chk1("t1_busy_locked", busy, 1'b1);
    wait_idle("t1");
    chki("t1_handshakes", log_q.size() - l0, 3);
    chkf("t1_head", out_head_flit, 16'h00A1);
    if (log_q.size() - l0 == 3) begin
      chkf("t1_f0", log_q[l0].d, 16'h00A1);
      chkf("t1_f2", log_q[l0+2].d, 16'h00A3);
    end

    // 2: both sources stream 2-flit packets -> strict alternation starting at NOC
    reset_pulse();
    after_neg();
    l0 = log_q.size();
    for (int p = 0; p < 4; p++) begin
      push_pkt(1'b0, flit_t'(16'h0010 + 2*p), 2, 1'b1);
      push_pkt(1'b1, flit_t'(16'h0020 + 2*p), 2, 1'b1);
    end
    wait_idle("t2");
    chki("t2_handshakes", log_q.size() - l0, 16);
    if (log_q.size() - l0 == 16) begin
      for (int k = 0; k < 8; k++) begin
        chk1("t2_src_head", log_q[l0+2*k].src, 1'(k % 2));
        chk1("t2_src_tail", log_q[l0+2*k+1].src, 1'(k % 2));
        chkf("t2_head_data", log_q[l0+2*k].d,
             flit_t'(((k % 2) ? 16'h0020 : 16'h0010) + 2*(k/2)));
      end
    end

    // 3: CPU keeps re-requesting against a long NOC backlog
    after_neg();
    l0 = log_q.size();
    push_pkt(1'b0, 16'h0030, 1, 1'b1); push_pkt(1'b0, 16'h0031, 1, 1'b1);
    push_pkt(1'b0, 16'h0032, 1, 1'b1); push_pkt(1'b0, 16'h0033, 1, 1'b1);
    push_pkt(1'b0, 16'h0034, 1, 1'b1); push_pkt(1'b0, 16'h0035, 1, 1'b1);
    push_pkt(1'b0, 16'h0036, 1, 1'b1); push_pkt(1'b0, 16'h0037, 1, 1'b1);
    push_pkt(1'b1, 16'h003A, 1, 1'b1); push_pkt(1'b1, 16'h003B, 1, 1'b1);
    push_pkt(1'b1, 16'h003C, 1, 1'b1);
    wait_idle("t3");
    chki("t3_handshakes", log_q.size() - l0, 11);
    if (log_q.size() - l0 == 11) begin
      for (int k = 0; k < 6; k++) chk1("t3_order", log_q[l0+k].src, 1'(k % 2));
      run = 0;
      for (int k = l0; k < log_q.size(); k++) begin
        if (log_q[k].src) begin
          chk1("t3_cpu_wait_bound", 1'(run <= NOC_WEIGHT), 1'b1);
          run = 0;
        end else begin
          run++;
        end
      end
    end

    // 4: router back-pressure mid-packet with CPU waiting
    after_neg();
    l0 = log_q.size();
    push_pkt(1'b0, 16'h0040, 3, 1'b1);
    wait_log("t4_first", l0 + 1);
    @(posedge nocclk); #1;
    out_flit_ready = 1'b0;
    push_pkt(1'b1, 16'h0050, 1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge nocclk); #1;
      chkf("t4_stall_flit", out_flit, 16'h0041);
      chk1("t4_stall_valid", out_flit_valid, 1'b1);
      chk1("t4_stall_cpu_ready", cpu_flit_ready, 1'b0);
    end
    #2;
    out_flit_ready = 1'b1;
    wait_idle("t4");
    chki("t4_handshakes", log_q.size() - l0, 4);
    if (log_q.size() - l0 == 4) begin
      chkf("t4_f1", log_q[l0+1].d, 16'h0041);
      chkf("t4_f2", log_q[l0+2].d, 16'h0042);
      chk1("t4_cpu_after", log_q[l0+3].src, 1'b1);
    end

    // 5: over-length NOC packet forces release, remainder re-arbitrates
    after_neg();
    chk1("t5_err_before", pkt_len_err, 1'b0);
    l0 = log_q.size();
    push_pkt(1'b0, 16'h0060, 16, 1'b0);
    push_pkt(1'b0, 16'h0070, 1, 1'b1);
    wait_idle("t5");
    chki("t5_handshakes", log_q.size() - l0, 17);
    chk1("t5_err_set", pkt_len_err, 1'b1);
    chkf("t5_new_head", out_head_flit, 16'h0070);
    if (log_q.size() - l0 == 17) chkf("t5_f15", log_q[l0+15].d, 16'h006F);

    // 6: asynchronous reset mid-packet, then a single-flit CPU packet
    after_neg();
    l0 = log_q.size();
    push_pkt(1'b0, 16'h0080, 3, 1'b1);
    wait_log("t6_first", l0 + 1);
    @(negedge nocclk); #3;
    rst_n = 1'b0;
    #1;
    chk1("t6_rst_valid", out_flit_valid, 1'b0);
    chk1("t6_rst_noc_ready", noc_flit_ready, 1'b0);
    chk1("t6_rst_busy", busy, 1'b0);
    chk1("t6_rst_err", pkt_len_err, 1'b0);
    chkf("t6_rst_head", out_head_flit, 16'h0000);
    noc_q.delete();
    cpu_q.delete();
    repeat (2) after_neg();
    rst_n = 1'b1;
    l0 = log_q.size();
    push_pkt(1'b1, 16'h0099, 1, 1'b1);
    wait_idle("t6");
    chki("t6_handshakes", log_q.size() - l0, 1);
    if (log_q.size() - l0 == 1) begin
      chk1("t6_src", log_q[l0].src, 1'b1);
      chkf("t6_data", log_q[l0].d, 16'h0099);
    end
    chkf("t6_head", out_head_flit, 16'h0099);
`ifdef PACKET_TRANSFER_ARBITER_STATS_EN
    chkc("t6_cpu_pkt_cnt", cpu_pkt_cnt, 16'd1);
    chkc("t6_noc_pkt_cnt", noc_pkt_cnt, 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
